muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that owns the architectural HI and LO registers.
- Sits beside the single-cycle ALU and supplies the HI/LO values that the mfhi/mflo result paths select.
- Accepts MULT/MULTU/DIV/DIVU plus mthi/mtlo writes.
- Asserts busy so the control unit can stall dependent mfhi/mflo.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

  // Counter width for a given operand width: one bit wider than log2 so WIDTH-1 always fits.
  function automatic int md_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns HI and LO.
// Handshake: start is accepted only when busy=0; done pulses one cycle as HI/LO take the result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e state, state_nx;

  logic                 div_q;
  logic                 sgn_q;   // product or quotient sign
  logic                 sgn_r;   // remainder sign
  logic [WIDTH-1:0]     m_q;     // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0]   acc;     // {upper, lower} product, or {rem, quot}
  logic [CNT_W-1:0]     cnt;

  logic                 is_div, is_signed, sa, sb, div0;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, rem_ext, diff;
  logic [2*WIDTH-1:0]   acc_mul_nx, acc_div_nx, prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Operand conditioning at launch
  always_comb begin
    is_div    = (op == MD_DIVU) || (op == MD_DIV);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    sa        = is_signed & opA[WIDTH-1];
    sb        = is_signed & opB[WIDTH-1];
    abs_a     = sa ? -opA : opA;
    abs_b     = sb ? -opB : opB;
    div0      = is_div && (opB == '0);
  end

  // One iteration of each algorithm; the state decides which one is kept
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    acc_mul_nx = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    rem_ext    = acc[2*WIDTH-1:WIDTH-1];
    diff       = rem_ext - {1'b0, m_q};
    acc_div_nx = diff[WIDTH] ? {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
  end

  // Sign fixup; divide-by-zero clears the flags at launch so results pass through raw
  always_comb begin
    prod_fix = sgn_q ? -acc : acc;
    if (div_q) begin
      res_hi = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIXUP;
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      m_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q <= is_div;
            cnt   <= '0;
            if (is_div) begin
              acc   <= {{WIDTH{1'b0}}, (div0 ? opA : abs_a)};
              m_q   <= abs_b;
              sgn_q <= ~div0 & (sa ^ sb);
              sgn_r <= ~div0 & sa;
            end else begin
              acc   <= {{WIDTH{1'b0}}, abs_b};
              m_q   <= abs_a;
              sgn_q <= sa ^ sb;
              sgn_r <= 1'b0;
            end
          end else begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= div_q ? acc_div_nx : acc_mul_nx;
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO queued at launch, checked by a done monitor.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] opa = '0, opb = '0, wdata = '0;
  logic         mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opa), .opB(opb),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // driver: launch one op, measure latency and busy span, optionally poke start/mtlo while busy
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int inject_at);
    int lat;
    int busy_cnt;
    bit seen;
    exp_q.push_back({exp_hi, exp_lo});
    @(posedge clk); #1;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = '0; opb = '0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      if (lat == inject_at) begin
        start = 1'b1; op = MD_DIVU; opa = 32'd99; opb = 32'd9;
        mtlo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else if (lat == inject_at + 1) begin
        start = 1'b0; mtlo_we = 1'b0; opa = '0; opb = '0;
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", lat, W + 2);
    check("busy_cycles", busy_cnt, W + 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    @(posedge clk); #1 mthi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1 mthi_we = 1'b0;
    @(negedge clk);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo_untouched", lo, 0);

    @(posedge clk); #1 mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1 mthi_we = 1'b0; mtlo_we = 1'b0;
    @(negedge clk);
    check("both_write", {hi, lo}, {32'h0000_ABCD, 32'h0000_ABCD});

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -10);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, -10);
    run_op(MD_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -10);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -10);
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -10);
    run_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        -10);
    run_op(MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, -10);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, -10);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -10);
    run_op(MD_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         5);

    // abort a divide with reset mid-flight
    @(posedge clk); #1 start = 1'b1; op = MD_DIVU; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_before_abort", busy, 1);
    check("hilo_held_while_busy", {hi, lo}, {32'd0, 32'd6});
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_hilo", {hi, lo}, 0);
    check("abort_busy", busy, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);

    run_op(MD_MULTU, 32'd4, 32'd4, 32'd0, 32'd16, -10);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
